// File: rtl/term_pkg.sv
// Shared definitions for the terminal ingress FIFO: header field offsets,
// destination legality check, statistics counter type and saturating increment.
package term_pkg;

    localparam int unsigned PCKG_SZ_DEF = 40;
    localparam int unsigned PKT_MAX     = 64;
    // Field LSBs are counted down from the packet MSB.
    localparam int unsigned ROW_OFS     = 12;
    localparam int unsigned COL_OFS     = 16;
    localparam int unsigned ID_LSB      = 10;
    localparam int unsigned ID_GAP      = 18;

    typedef logic [15:0] stat_t;
    localparam stat_t STAT_MAX = 16'hFFFF;

    // Broadcast IDs pass, otherwise the coordinate must be a non-corner border cell.
    function automatic logic is_legal_dst(
        input logic [PKT_MAX-1:0] pkt,
        input int unsigned        sz,
        input int unsigned        rows,
        input int unsigned        colums,
        input logic [PKT_MAX-1:0] bcast_id
    );
        logic [PKT_MAX-1:0] id_mask;
        int unsigned        row_u;
        int unsigned        col_u;
        logic               bcast;
        logic               in_range;
        logic               border;
        logic               corner;
        id_mask  = {PKT_MAX{1'b1}} >> (PKT_MAX - (sz - ID_GAP));
        bcast    = (((pkt >> ID_LSB) & id_mask) == (bcast_id & id_mask));
        row_u    = 32'((pkt >> (sz - ROW_OFS)) & 64'hF);
        col_u    = 32'((pkt >> (sz - COL_OFS)) & 64'hF);
        in_range = (row_u <= rows + 32'd1) && (col_u <= colums + 32'd1);
        border   = (row_u == 32'd0) || (row_u == rows + 32'd1) ||
                   (col_u == 32'd0) || (col_u == colums + 32'd1);
        corner   = ((row_u == 32'd0) || (row_u == rows + 32'd1)) &&
                   ((col_u == 32'd0) || (col_u == colums + 32'd1));
        return bcast || (in_range && border && !corner);
    endfunction

    function automatic stat_t sat_inc(input stat_t v, input logic en);
        return (en && (v != STAT_MAX)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/term_fifo_core.sv
// Show-ahead FIFO storage: memory, wrapping pointers and occupancy count.
// A write into a full FIFO is accepted only when a read retires the head in the same cycle.
module term_fifo_core #(
    parameter int unsigned DW    = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_i,
    input  logic [DW-1:0]            wr_data_i,
    input  logic                     rd_i,
    output logic [DW-1:0]            rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     wr_ok_o
);
    import term_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_ok_s;
    logic          wr_ok_s;

    // Qualify requests and compute next pointer/count state.
    always_comb begin
        rd_ok_s = rd_i && (count_q != {CW{1'b0}});
        wr_ok_s = wr_i && ((count_q != CW'(DEPTH)) || rd_ok_s);
        wptr_d  = wr_ok_s ? wptr_q + {{(AW-1){1'b0}}, 1'b1} : wptr_q;
        rptr_d  = rd_ok_s ? rptr_q + {{(AW-1){1'b0}}, 1'b1} : rptr_q;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care after reset since reads are gated by count.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    assign empty_o   = (count_q == {CW{1'b0}});
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign wr_ok_o   = wr_ok_s;
    assign rd_data_o = empty_o ? {DW{1'b0}} : mem_q[rptr_q];

endmodule

// File: rtl/term_in_fifo.sv
// Terminal ingress buffer: destination check, show-ahead FIFO, overflow/illegal flags.
// Define TERM_IN_FIFO_STATS_EN to add saturating accept/pop/drop counters.
module term_in_fifo
    import term_pkg::*;
#(
    parameter int unsigned              pckg_sz    = 40,
    parameter int unsigned              fifo_depth = 4,
    parameter int unsigned              ROWS       = 4,
    parameter int unsigned              COLUMS     = 4,
    parameter logic [pckg_sz-19:0]      bdcst      = {(pckg_sz-18){1'b1}}
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [pckg_sz-1:0]              data_in,
    output logic                            full,
    output logic [pckg_sz-1:0]              data_out_i_in,
    output logic                            pndng_i_in,
    input  logic                            popin,
    output logic [$clog2(fifo_depth):0]     count,
    output logic                            ovf,
    output logic                            err_dst
`ifdef TERM_IN_FIFO_STATS_EN
    ,
    output stat_t                           stat_acc,
    output stat_t                           stat_pop,
    output stat_t                           stat_drop
`endif
);

    logic legal_s;
    logic wr_req_s;
    logic wr_ok_s;
    logic empty_s;
    logic drop_ill_s;
    logic drop_ovf_s;
    logic ovf_q, ovf_d;
    logic err_dst_q, err_dst_d;

    term_fifo_core #(
        .DW    (pckg_sz),
        .DEPTH (fifo_depth)
    ) u_core (
        .clk       (clk),
        .rst_n     (reset),
        .wr_i      (wr_req_s),
        .wr_data_i (data_in),
        .rd_i      (popin),
        .rd_data_o (data_out_i_in),
        .full_o    (full),
        .empty_o   (empty_s),
        .count_o   (count),
        .wr_ok_o   (wr_ok_s)
    );

    // Header check; an illegal destination wins over a full FIFO.
    always_comb begin
        legal_s    = is_legal_dst(PKT_MAX'(data_in), pckg_sz, ROWS, COLUMS, PKT_MAX'(bdcst));
        wr_req_s   = push && legal_s;
        drop_ill_s = push && !legal_s;
        drop_ovf_s = wr_req_s && !wr_ok_s;
        ovf_d      = ovf_q || drop_ovf_s;
        err_dst_d  = drop_ill_s;
    end

    // Sticky overflow flag and single-cycle illegal-destination pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q     <= 1'b0;
            err_dst_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            err_dst_q <= err_dst_d;
        end
    end

    assign pndng_i_in = !empty_s;
    assign ovf        = ovf_q;
    assign err_dst    = err_dst_q;

`ifdef TERM_IN_FIFO_STATS_EN
    stat_t stat_acc_q;
    stat_t stat_pop_q;
    stat_t stat_drop_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_acc_q  <= 16'd0;
            stat_pop_q  <= 16'd0;
            stat_drop_q <= 16'd0;
        end else begin
            stat_acc_q  <= sat_inc(stat_acc_q, wr_ok_s);
            stat_pop_q  <= sat_inc(stat_pop_q, popin && !empty_s);
            stat_drop_q <= sat_inc(stat_drop_q, drop_ill_s || drop_ovf_s);
        end
    end

    assign stat_acc  = stat_acc_q;
    assign stat_pop  = stat_pop_q;
    assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_term_in_fifo.sv
// Directed bench for term_in_fifo with a queue scoreboard and a small occupancy model.
module tb_term_in_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [39:0] data_in;
    logic        full;
    logic [39:0] data_out_i_in;
    logic        pndng_i_in;
    logic        popin;
    logic [2:0]  count;
    logic        ovf;
    logic        err_dst;
`ifdef TERM_IN_FIFO_STATS_EN
    logic [15:0] stat_acc;
    logic [15:0] stat_pop;
    logic [15:0] stat_drop;
    int          m_acc, m_pop, m_drop;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [39:0] sb_q[$];
    int          m_cnt;
    logic        m_ovf;
    logic        m_err;

    term_in_fifo dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .data_in       (data_in),
        .full          (full),
        .data_out_i_in (data_out_i_in),
        .pndng_i_in    (pndng_i_in),
        .popin         (popin),
        .count         (count),
        .ovf           (ovf),
        .err_dst       (err_dst)
`ifdef TERM_IN_FIFO_STATS_EN
        ,
        .stat_acc      (stat_acc),
        .stat_pop      (stat_pop),
        .stat_drop     (stat_drop)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [3:0] row, input logic [3:0] col, input logic [23:0] pay);
        return {8'h00, row, col, pay};
    endfunction

    function automatic logic tb_legal(input logic [39:0] p);
        logic [3:0] r;
        logic [3:0] c;
        logic       redge;
        logic       cedge;
        r     = p[31:28];
        c     = p[27:24];
        redge = (r == 4'd0) || (r == 4'd5);
        cedge = (c == 4'd0) || (c == 4'd5);
        return (p[31:10] == 22'h3FFFFF) ||
               ((r <= 4'd5) && (c <= 4'd5) && (redge || cedge) && !(redge && cedge));
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_count"}, 64'(count), 64'(m_cnt));
        check({tag, "_pndng"}, 64'(pndng_i_in), 64'(m_cnt != 0));
        check({tag, "_full"},  64'(full), 64'(m_cnt == 4));
        check({tag, "_ovf"},   64'(ovf), 64'(m_ovf));
        check({tag, "_err"},   64'(err_dst), 64'(m_err));
        if (m_cnt == 0) check({tag, "_head0"}, 64'(data_out_i_in), 64'd0);
        else            check({tag, "_head"},  64'(data_out_i_in), 64'(sb_q[0]));
    endtask

    task automatic cyc(input string tag, input logic p, input logic [39:0] d, input logic pp);
        logic        legal;
        logic        popok;
        logic        acc;
        logic [39:0] exp_head;
        legal = tb_legal(d);
        popok = pp && (m_cnt > 0);
        acc   = p && legal && ((m_cnt < 4) || popok);
        push = p; data_in = d; popin = pp;
        if (popok) begin
            exp_head = sb_q.pop_front();
            check({tag, "_popdata"}, 64'(data_out_i_in), 64'(exp_head));
        end
        if (acc) sb_q.push_back(d);
        m_err = p && !legal;
        if (p && legal && !acc) m_ovf = 1'b1;
        m_cnt = m_cnt + int'(acc) - int'(popok);
`ifdef TERM_IN_FIFO_STATS_EN
        m_acc  += int'(acc);
        m_pop  += int'(popok);
        m_drop += int'(p && !acc);
`endif
        @(posedge clk);
        #1;
        push = 1'b0; popin = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        sb_q.delete();
        m_cnt = 0; m_ovf = 1'b0; m_err = 1'b0;
`ifdef TERM_IN_FIFO_STATS_EN
        m_acc = 0; m_pop = 0; m_drop = 0;
`endif
        check_state("rst");
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        push = 1'b0; popin = 1'b0; data_in = 40'd0; reset = 1'b1;
        m_cnt = 0; m_ovf = 1'b0; m_err = 1'b0;
        #2;
        do_reset();

        // Single packet in and out.
        cyc("one_push", 1'b1, mk(4'd0, 4'd1, 24'h1), 1'b0);
        cyc("one_pop",  1'b0, 40'd0, 1'b1);

        // Fill, overflow, drain in order.
        cyc("fill1", 1'b1, mk(4'd0, 4'd2, 24'h1), 1'b0);
        cyc("fill2", 1'b1, mk(4'd5, 4'd3, 24'h2), 1'b0);
        cyc("fill3", 1'b1, mk(4'd2, 4'd0, 24'h3), 1'b0);
        cyc("fill4", 1'b1, mk(4'd3, 4'd5, 24'h4), 1'b0);
        cyc("ovf5",  1'b1, mk(4'd1, 4'd5, 24'h5), 1'b0);
        for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 40'd0, 1'b1);
        cyc("ovf_hold", 1'b0, 40'd0, 1'b0);

        // Illegal destinations.
        do_reset();
        cyc("corner", 1'b1, mk(4'd0, 4'd0, 24'hA), 1'b0);
        cyc("range",  1'b1, mk(4'd6, 4'd2, 24'hB), 1'b0);
        cyc("corner2", 1'b1, mk(4'd5, 4'd5, 24'hC), 1'b0);
        cyc("inner",  1'b1, mk(4'd2, 4'd2, 24'hD), 1'b0);
        cyc("idle",   1'b0, 40'd0, 1'b0);

        // Full plus simultaneous push/pop.
        for (int i = 0; i < 4; i++) cyc("fill", 1'b1, mk(4'd5, 4'd1, 24'(i + 16)), 1'b0);
        cyc("full_pp", 1'b1, mk(4'd0, 4'd4, 24'hEE), 1'b1);
        for (int i = 0; i < 4; i++) cyc("drain2", 1'b0, 40'd0, 1'b1);

        // Broadcast, empty pop, empty push+pop.
        cyc("bcast",     1'b1, {8'h00, 22'h3FFFFF, 10'h155}, 1'b0);
        cyc("bcast_pop", 1'b0, 40'd0, 1'b1);
        cyc("empty_pop", 1'b0, 40'd0, 1'b1);
        cyc("empty_pp",  1'b1, mk(4'd4, 4'd0, 24'h77), 1'b1);
        cyc("pop77",     1'b0, 40'd0, 1'b1);

        // Asynchronous reset with entries held.
        for (int i = 0; i < 3; i++) cyc("pre_rst", 1'b1, mk(4'd1, 4'd0, 24'(i + 32)), 1'b0);
        #2;
        reset = 1'b0;
        popin = 1'b1;
        #1;
        check("async_count", 64'(count), 64'd0);
        check("async_pndng", 64'(pndng_i_in), 64'd0);
        check("async_head",  64'(data_out_i_in), 64'd0);
        popin = 1'b0;
        do_reset();

`ifdef TERM_IN_FIFO_STATS_EN
        for (int i = 0; i < 4; i++) cyc("st_fill", 1'b1, mk(4'd0, 4'd3, 24'(i + 48)), 1'b0);
        cyc("st_ovf", 1'b1, mk(4'd0, 4'd3, 24'h99), 1'b0);
        cyc("st_ill1", 1'b1, mk(4'd0, 4'd0, 24'h1), 1'b0);
        cyc("st_ill2", 1'b1, mk(4'd7, 4'd1, 24'h2), 1'b0);
        for (int i = 0; i < 4; i++) cyc("st_drain", 1'b0, 40'd0, 1'b1);
        check("stat_acc",  64'(stat_acc),  64'd4);
        check("stat_drop", 64'(stat_drop), 64'd3);
        check("stat_pop",  64'(stat_pop),  64'd4);
        check("stat_acc_m", 64'(stat_acc), 64'(m_acc));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/term_in_fifo.md
Name: term_in_fifo

Overview:
- Per-terminal ingress buffer between a host/agent port and one external terminal of mesh_gnrtr.
- Accepts packets on a push interface, checks the destination header, and stores legal packets in a show-ahead FIFO.
- Presents the FIFO head to the mesh as data_out_i_in / pndng_i_in; the mesh removes the head with popin.
- One instance per terminal: ROWS*2 + COLUMS*2 instances per mesh.

Parameters:
- pckg_sz, 40, packet width in bits.
- fifo_depth, 4, FIFO entries; power of two, at least 2.
- ROWS, 4, mesh rows, used for destination range check.
- COLUMS, 4, mesh columns, used for destination range check.
- bdcst, {pckg_sz-18{1'b1}}, broadcast ID value.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  host write strobe.
- data_in  in  pckg_sz  host packet.
- full  out  1  FIFO holds fifo_depth entries.
- data_out_i_in  out  pckg_sz  FIFO head toward the mesh (show-ahead).
- pndng_i_in  out  1  FIFO not empty.
- popin  in  1  mesh consumes the head this cycle.
- count  out  $clog2(fifo_depth)+1  current occupancy.
- ovf  out  1  sticky: a push was refused because the FIFO was full.
- err_dst  out  1  one-cycle pulse: a packet was dropped for an illegal destination.

Behaviour:
- Header fields:
  - [pckg_sz-9:pckg_sz-12] is dst_row.
  - [pckg_sz-13:pckg_sz-16] is dst_col.
  - A packet is broadcast when [pckg_sz-9:pckg_sz-(9+($bits(bdcst)-1))] equals bdcst, i.e. all ones in the ID field.
- Legal destination: broadcast, or (dst_row <= ROWS+1 and dst_col <= COLUMS+1 and the coordinate is on the mesh border).
  - Border means dst_row is 0 or ROWS+1, or dst_col is 0 or COLUMS+1.
  - Corner coordinates (0,0), (0,COLUMS+1), (ROWS+1,0), (ROWS+1,COLUMS+1) are illegal.
- Reset (reset low, asynchronous):
  - Read and write pointers, count, ovf and err_dst all go to 0.
  - pndng_i_in = 0, full = 0, data_out_i_in = 0.
  - Memory contents are don't-care.
- Push:
  - Legal, not full: data written at wptr, wptr increments with wrap at fifo_depth, count +1.
  - Illegal destination: packet not written; err_dst = 1 on the next cycle only. The illegal check takes precedence over full.
  - Legal, full, no popin in the same cycle: packet dropped, ovf set and held until reset.
- Pop:
  - popin with pndng_i_in = 1: rptr increments with wrap, count -1.
  - popin with empty FIFO: ignored; no state change and no error.
- Simultaneous push and popin:
  - Full FIFO: both accepted, count unchanged, no ovf.
  - Empty FIFO: push accepted, popin ignored, count becomes 1.
- Latency:
  - data_out_i_in = mem[rptr] combinationally; 0 when empty.
  - A packet pushed at edge N is visible with pndng_i_in = 1 after edge N; it can be popped at edge N+1.
- full = (count == fifo_depth); pndng_i_in = (count != 0). Both are registered-state derived, with no combinational path from push or popin.
- Reset asserted mid-operation discards all contents; popin during reset has no effect.

Optional Feature:
- Macro: TERM_IN_FIFO_STATS_EN.
- When defined, three 16-bit saturating counters are added: stat_acc (accepted pushes), stat_pop (successful pops), stat_drop (illegal plus overflow drops).
  - They are output on ports stat_acc, stat_pop, stat_drop.
  - Cleared by reset; each holds at 16'hFFFF once reached.
- When undefined, those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package term_pkg holds:
  - Header field offset localparams derived from pckg_sz.
  - Function is_legal_dst(pkt, ROWS, COLUMS).
  - typedef of the counter width.
- Sub-module term_fifo_core: the pure memory, pointer and count logic with push/pop/full/empty.
- term_in_fifo wraps term_fifo_core with header check, ovf/err_dst and the optional stats.

Test Plan:
- Reset, then push dst (0,1) payload 0x1 -> pndng_i_in = 1 next cycle, data_out_i_in = pushed word, count = 1; popin -> count = 0, data_out_i_in = 0.
- 5 legal pushes, no pops, fifo_depth = 4 -> full = 1 after the 4th; 5th dropped; ovf = 1 stays high; pop order equals push order 1..4.
- Push dst (0,0) corner, then (6,2) out of range -> two err_dst pulses; count stays 0; pndng_i_in stays 0.
- Full FIFO plus simultaneous legal push and popin -> count stays 4, ovf = 0, new packet returned last after 4 pops.
- Broadcast ID push -> accepted; popin on empty FIFO -> no change; assert reset with 3 entries -> count = 0, pndng_i_in = 0 immediately (before next edge).
- With TERM_IN_FIFO_STATS_EN: 4 accepted, 1 overflow, 2 illegal, 4 pops -> stat_acc = 4, stat_drop = 3, stat_pop = 4.
